core_control_unit: RTL and testbench
====================================

// Module: core_control_unit
// PURPOSE
//   Multi-cycle fetch/decode/execute sequencer for the core datapath.
//   Generates the datapath load strobes (ld_sp/ld_lr/ld_pc/ld_rd/ld_apsr/ld_ipsr/ld_primask),
//   memory write enable and cu_decode. Also handles memory wait handshakes,
//   IRQ entry at instruction boundaries and the undefined/timeout fault.
//   Sits beside the datapath; consumes the decoded instruction class and memory ready.
// PARAMETERS
//   MEM_TIMEOUT  15     max wait cycles for mem_ready before fault (4-bit counter)
//   EXC_IRQ      6'd16  IPSR exception number driven on IRQ entry
//   EXC_FAULT    6'd3   IPSR exception number for undefined instr / mem timeout
// PORTS
//   clk         in   1  clock; all state changes on posedge
//   rst         in   1  synchronous active-high reset
//   inst_class  in   3  decoded class: 0 DP, 1 LOAD, 2 STORE, 3 B, 4 BL, 5 SYS(primask), 6 NOP, 7 UNDEF
//   set_flags   in   1  S bit of current instruction
//   mem_ready   in   1  memory has completed the current fetch or data access
//   irq_req     in   1  level interrupt request
//   primask     in   1  current PMask; 1 masks irq_req
//   halt        in   1  stop at the next instruction boundary
//   mem_req     out  1  fetch or data access request, held until mem_ready
//   wr_en       out  1  data store write enable
//   cu_decode   out  1  decode strobe to the instruction register
//   ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask  out 1 each  single-cycle load strobes
//   pc_sel      out  2  0 PC+4, 1 branch target, 2 vector, 3 hold
//   exc_num     out  6  value for w_IPSR; valid while ld_ipsr=1, else 0
//   irq_ack     out  1  one-cycle pulse on IRQ entry
//   state_o     out  3  current state, for debug
// BEHAVIOUR
//   States: RESET=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 EXC=6 HALT=7. Outputs decoded from the registered state (Moore) plus inst_class.
//   Reset: state=RESET, wait counter=0. Every output is 0 and pc_sel=3. RESET goes to the boundary check on the next cycle.
//   Boundary check (leaving RESET or WB, and after single-cycle EXEC classes):
//     priority irq_req&!primask -> EXC; else halt -> HALT; else FETCH.
//   FETCH: mem_req=1 until mem_ready, then DECODE.
//   DECODE: cu_decode=1 for exactly one cycle, then EXEC.
//   EXEC, one cycle:
//     DP    ld_rd=1, ld_apsr=set_flags, ld_pc=1, pc_sel=0
//     B     ld_pc=1, pc_sel=1
//     BL    ld_lr=1, ld_pc=1, pc_sel=1
//     SYS   ld_primask=1, ld_pc=1, pc_sel=0
//     NOP   ld_pc=1, pc_sel=0
//     These classes then go to the boundary check.
//     LOAD/STORE -> MEM. UNDEF -> EXC with fault cause.
//   MEM: mem_req=1, and wr_en=1 for STORE. Held until mem_ready, then WB. wr_en drops the same cycle as the exit.
//   WB: ld_rd=1 for LOAD only; ld_pc=1, pc_sel=0; then boundary check.
//   Wait counter: clears on entry to FETCH/MEM and increments each cycle mem_ready=0.
//     When it reaches MEM_TIMEOUT with mem_ready=0 -> EXC with fault cause, and mem_req drops.
//     mem_ready in the same cycle as the count reaching MEM_TIMEOUT wins; no fault.
//   EXC: two cycles.
//     E0: ld_sp=1, ld_lr=1.
//     E1: ld_ipsr=1, exc_num=cause, ld_pc=1, pc_sel=2, irq_ack=1 (IRQ cause only); then FETCH.
//     Fault cause wins over a simultaneous IRQ. No boundary check after E1; this gives one guaranteed handler instruction.
//   HALT: all strobes 0, pc_sel=3. Exits to the boundary check when halt=0; an IRQ still wakes HALT.
//   At most one ld_* group per cycle as listed; no strobe is ever asserted longer than one cycle.
//   rst mid-operation: returns to RESET on the next edge from any state. Outstanding mem_req and wr_en drop that edge.
// TESTING
//   1. rst 3 cycles then DP, set_flags=1, mem_ready after 2 waits -> FETCH 3 cycles, cu_decode 1 cycle,
//      then ld_rd=ld_apsr=ld_pc=1 in one cycle, pc_sel=0.
//   2. LOAD, data mem_ready after 1 wait -> MEM 2 cycles with wr_en=0, then WB ld_rd=1 ld_pc=1.
//      STORE: same, but wr_en=1 for both MEM cycles and ld_rd=0.
//   3. BL -> ld_lr=ld_pc=1, pc_sel=1 in EXEC. irq_req=1, primask=0 during EXEC -> EXC next:
//      ld_sp/ld_lr, then ld_ipsr with exc_num=16, pc_sel=2, irq_ack=1.
//   4. irq_req=1, primask=1 -> no EXC for 3 instructions; primask=0 -> EXC at the next boundary.
//   5. mem_ready stuck 0 in FETCH -> after 15 wait cycles EXC with exc_num=3, mem_req low.
//      UNDEF class -> same exc_num=3 via EXEC.
//   6. halt=1 -> HALT after current WB, all strobes 0. rst asserted during MEM with wr_en=1 -> next cycle state=0, wr_en=0.

Source files
------------

// File: rtl/core_control_unit.sv
// core_control_unit: multi-cycle fetch/decode/execute sequencer.
// Drives the datapath load strobes, memory request/write enable and the
// decode strobe. It also takes IRQs at instruction boundaries and raises a
// fault on an undefined instruction or a memory wait timeout.
//
// Handshake: mem_req is a level request. It stays high in FETCH or MEM
// until the cycle in which mem_ready is sampled high, and that cycle
// completes the transfer. No transfer is assumed before mem_ready.
module core_control_unit #(
    parameter logic [3:0] MEM_TIMEOUT = 4'd15,
    parameter logic [5:0] EXC_IRQ     = 6'd16,
    parameter logic [5:0] EXC_FAULT   = 6'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] inst_class,
    input  logic       set_flags,
    input  logic       mem_ready,
    input  logic       irq_req,
    input  logic       primask,
    input  logic       halt,
    output logic       mem_req,
    output logic       wr_en,
    output logic       cu_decode,
    output logic       ld_sp,
    output logic       ld_lr,
    output logic       ld_pc,
    output logic       ld_rd,
    output logic       ld_apsr,
    output logic       ld_ipsr,
    output logic       ld_primask,
    output logic [1:0] pc_sel,
    output logic [5:0] exc_num,
    output logic       irq_ack,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_EXC    = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [2:0] CL_DP    = 3'd0;
    localparam logic [2:0] CL_LOAD  = 3'd1;
    localparam logic [2:0] CL_STORE = 3'd2;
    localparam logic [2:0] CL_B     = 3'd3;
    localparam logic [2:0] CL_BL    = 3'd4;
    localparam logic [2:0] CL_SYS   = 3'd5;
    localparam logic [2:0] CL_NOP   = 3'd6;
    localparam logic [2:0] CL_UNDEF = 3'd7;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_VEC  = 2'd2;
    localparam logic [1:0] PC_HOLD = 2'd3;

    state_t     state, state_nx;
    logic [3:0] wait_cnt, wait_cnt_nx;
    logic       exc_phase, exc_phase_nx;     // 0: stack/LR save, 1: vector load
    logic       cause_fault, cause_fault_nx; // 1: fault, 0: IRQ
    logic       irq_pending;
    state_t     bnd_state;

    assign irq_pending = irq_req & ~primask;

    // Instruction-boundary decision: unmasked IRQ, then halt, else fetch.
    always_comb begin
        bnd_state = ST_FETCH;
        if (irq_pending) begin
            bnd_state = ST_EXC;
        end else if (halt) begin
            bnd_state = ST_HALT;
        end
    end

    // State, wait counter, exception phase and cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RESET;
            wait_cnt    <= 4'd0;
            exc_phase   <= 1'b0;
            cause_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            exc_phase   <= exc_phase_nx;
            cause_fault <= cause_fault_nx;
        end
    end

    // Next-state logic, including wait-timeout and exception entry.
    always_comb begin
        state_nx       = state;
        wait_cnt_nx    = wait_cnt;
        exc_phase_nx   = exc_phase;
        cause_fault_nx = cause_fault;

        case (state)
            ST_RESET, ST_WB, ST_HALT: begin
                // In HALT this holds HALT while halt=1 and no IRQ is pending.
                state_nx       = bnd_state;
                cause_fault_nx = 1'b0;
            end
            ST_FETCH, ST_MEM: begin
                if (mem_ready) begin
                    state_nx = (state == ST_FETCH) ? ST_DECODE : ST_WB;
                end else if (wait_cnt == MEM_TIMEOUT) begin
                    state_nx       = ST_EXC;
                    cause_fault_nx = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 4'd1;
                end
            end
            ST_DECODE: begin
                state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                case (inst_class)
                    CL_LOAD, CL_STORE: state_nx = ST_MEM;
                    CL_UNDEF: begin
                        state_nx       = ST_EXC;
                        cause_fault_nx = 1'b1;
                    end
                    default: begin
                        state_nx       = bnd_state;
                        cause_fault_nx = 1'b0;
                    end
                endcase
            end
            ST_EXC: begin
                // No boundary check after the vector load, so the handler
                // always gets its first instruction.
                if (exc_phase) begin
                    state_nx = ST_FETCH;
                end else begin
                    exc_phase_nx = 1'b1;
                end
            end
            default: state_nx = ST_RESET;
        endcase

        // Fresh wait budget for every new memory access.
        if ((state_nx == ST_FETCH || state_nx == ST_MEM) && state_nx != state) begin
            wait_cnt_nx = 4'd0;
        end
        if (state_nx == ST_EXC && state != ST_EXC) begin
            exc_phase_nx = 1'b0;
        end
    end

    // Moore outputs from the registered state, qualified by inst_class.
    always_comb begin
        mem_req    = 1'b0;
        wr_en      = 1'b0;
        cu_decode  = 1'b0;
        ld_sp      = 1'b0;
        ld_lr      = 1'b0;
        ld_pc      = 1'b0;
        ld_rd      = 1'b0;
        ld_apsr    = 1'b0;
        ld_ipsr    = 1'b0;
        ld_primask = 1'b0;
        pc_sel     = PC_HOLD;
        exc_num    = 6'd0;
        irq_ack    = 1'b0;

        case (state)
            ST_FETCH: mem_req = 1'b1;
            ST_DECODE: cu_decode = 1'b1;
            ST_EXEC: begin
                case (inst_class)
                    CL_DP: begin
                        ld_rd   = 1'b1;
                        ld_apsr = set_flags;
                        ld_pc   = 1'b1;
                        pc_sel  = PC_INC;
                    end
                    CL_B: begin
                        ld_pc  = 1'b1;
                        pc_sel = PC_BR;
                    end
                    CL_BL: begin
                        ld_lr  = 1'b1;
                        ld_pc  = 1'b1;
                        pc_sel = PC_BR;
                    end
                    CL_SYS: begin
                        ld_primask = 1'b1;
                        ld_pc      = 1'b1;
                        pc_sel     = PC_INC;
                    end
                    CL_NOP: begin
                        ld_pc  = 1'b1;
                        pc_sel = PC_INC;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                wr_en   = (inst_class == CL_STORE);
            end
            ST_WB: begin
                ld_rd  = (inst_class == CL_LOAD);
                ld_pc  = 1'b1;
                pc_sel = PC_INC;
            end
            ST_EXC: begin
                if (!exc_phase) begin
                    ld_sp = 1'b1;
                    ld_lr = 1'b1;
                end else begin
                    ld_ipsr = 1'b1;
                    exc_num = cause_fault ? EXC_FAULT : EXC_IRQ;
                    ld_pc   = 1'b1;
                    pc_sel  = PC_VEC;
                    irq_ack = ~cause_fault;
                end
            end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_core_control_unit.sv
// Directed bench for core_control_unit. Each scenario task builds a table of
// per-cycle inputs and hand-computed expected outputs, then steps it.
// Inputs change on the falling edge, and outputs are compared 1 ns later.
module tb_core_control_unit;

    logic       clk;
    logic       rst;
    logic [2:0] inst_class;
    logic       set_flags;
    logic       mem_ready;
    logic       irq_req;
    logic       primask;
    logic       halt;
    logic       mem_req, wr_en, cu_decode;
    logic       ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask;
    logic [1:0] pc_sel;
    logic [5:0] exc_num;
    logic       irq_ack;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe bit positions inside the packed observation vector.
    localparam logic [10:0] B_MREQ = 11'h400;
    localparam logic [10:0] B_WR   = 11'h200;
    localparam logic [10:0] B_DEC  = 11'h100;
    localparam logic [10:0] B_SP   = 11'h080;
    localparam logic [10:0] B_LR   = 11'h040;
    localparam logic [10:0] B_PC   = 11'h020;
    localparam logic [10:0] B_RD   = 11'h010;
    localparam logic [10:0] B_APSR = 11'h008;
    localparam logic [10:0] B_IPSR = 11'h004;
    localparam logic [10:0] B_PM   = 11'h002;
    localparam logic [10:0] B_ACK  = 11'h001;

    localparam logic [2:0] S_RST = 3'd0, S_FET = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB  = 3'd5, S_EXC = 3'd6, S_HLT = 3'd7;

    localparam logic [2:0] C_DP = 3'd0, C_LD = 3'd1, C_ST = 3'd2, C_B = 3'd3;
    localparam logic [2:0] C_BL = 3'd4, C_SYS = 3'd5, C_NOP = 3'd6, C_UND = 3'd7;

    logic [21:0] obs;
    assign obs = {mem_req, wr_en, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr,
                  ld_ipsr, ld_primask, irq_ack, pc_sel, exc_num, state_o};

    core_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .inst_class (inst_class),
        .set_flags  (set_flags),
        .mem_ready  (mem_ready),
        .irq_req    (irq_req),
        .primask    (primask),
        .halt       (halt),
        .mem_req    (mem_req),
        .wr_en      (wr_en),
        .cu_decode  (cu_decode),
        .ld_sp      (ld_sp),
        .ld_lr      (ld_lr),
        .ld_pc      (ld_pc),
        .ld_rd      (ld_rd),
        .ld_apsr    (ld_apsr),
        .ld_ipsr    (ld_ipsr),
        .ld_primask (ld_primask),
        .pc_sel     (pc_sel),
        .exc_num    (exc_num),
        .irq_ack    (irq_ack),
        .state_o    (state_o)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] iv(logic r, logic [2:0] c, logic sf, logic mr,
                                      logic irq, logic pm, logic h);
        return {r, c, sf, mr, irq, pm, h};
    endfunction

    function automatic logic [21:0] ev(logic [2:0] st, logic [10:0] sb,
                                       logic [1:0] ps, logic [5:0] ex);
        return {sb, ps, ex, st};
    endfunction

    logic [8:0]  vin[$];
    logic [21:0] vexp[$];

    task automatic test_reset();
        vin.delete(); vexp.delete();
        vin.push_back(iv(1, C_DP, 1, 0, 0, 0, 0)); vexp.push_back(ev(S_RST, 0, 3, 0));
        vin.push_back(iv(1, C_DP, 1, 0, 0, 0, 0)); vexp.push_back(ev(S_RST, 0, 3, 0));
        vin.push_back(iv(0, C_DP, 1, 0, 0, 0, 0)); vexp.push_back(ev(S_RST, 0, 3, 0));
        for (int i = 0; i < vin.size(); i++) begin
            {rst, inst_class, set_flags, mem_ready, irq_req, primask, halt} = vin[i];
            #1;
            n_checks++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL reset row %0d: got st=%0d strb=%b pc=%0d exc=%0d, want st=%0d strb=%b pc=%0d exc=%0d",
                         i, obs[2:0], obs[21:11], obs[10:9], obs[8:3],
                         vexp[i][2:0], vexp[i][21:11], vexp[i][10:9], vexp[i][8:3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dp();
        vin.delete(); vexp.delete();
        vin.push_back(iv(0, C_DP, 1, 0, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_DP, 1, 0, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_DP, 1, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_DP, 1, 0, 0, 0, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_DP, 1, 0, 0, 0, 0)); vexp.push_back(ev(S_EXE, B_RD | B_APSR | B_PC, 0, 0));
        // Back-to-back B then SYS instruction, both single-cycle EXEC.
        vin.push_back(iv(0, C_B, 0, 1, 0, 0, 0));   vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_B, 0, 0, 0, 0, 0));   vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_B, 0, 0, 0, 0, 0));   vexp.push_back(ev(S_EXE, B_PC, 1, 0));
        vin.push_back(iv(0, C_SYS, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_SYS, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_SYS, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXE, B_PM | B_PC, 0, 0));
        for (int i = 0; i < vin.size(); i++) begin
            {rst, inst_class, set_flags, mem_ready, irq_req, primask, halt} = vin[i];
            #1;
            n_checks++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL dp_branch row %0d: got st=%0d strb=%b pc=%0d exc=%0d, want st=%0d strb=%b pc=%0d exc=%0d",
                         i, obs[2:0], obs[21:11], obs[10:9], obs[8:3],
                         vexp[i][2:0], vexp[i][21:11], vexp[i][10:9], vexp[i][8:3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_store();
        vin.delete(); vexp.delete();
        vin.push_back(iv(0, C_LD, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXE, 0, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_MEM, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_MEM, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_WB, B_RD | B_PC, 0, 0));
        vin.push_back(iv(0, C_ST, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXE, 0, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_MEM, B_MREQ | B_WR, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_MEM, B_MREQ | B_WR, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_WB, B_PC, 0, 0));
        for (int i = 0; i < vin.size(); i++) begin
            {rst, inst_class, set_flags, mem_ready, irq_req, primask, halt} = vin[i];
            #1;
            n_checks++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL load_store row %0d: got st=%0d strb=%b pc=%0d exc=%0d, want st=%0d strb=%b pc=%0d exc=%0d",
                         i, obs[2:0], obs[21:11], obs[10:9], obs[8:3],
                         vexp[i][2:0], vexp[i][21:11], vexp[i][10:9], vexp[i][8:3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_irq_bl();
        vin.delete(); vexp.delete();
        vin.push_back(iv(0, C_BL, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_BL, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_BL, 0, 0, 1, 0, 0)); vexp.push_back(ev(S_EXE, B_LR | B_PC, 1, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_SP | B_LR, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_IPSR | B_PC | B_ACK, 2, 6'd16));
        for (int i = 0; i < vin.size(); i++) begin
            {rst, inst_class, set_flags, mem_ready, irq_req, primask, halt} = vin[i];
            #1;
            n_checks++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL irq_bl row %0d: got st=%0d strb=%b pc=%0d exc=%0d, want st=%0d strb=%b pc=%0d exc=%0d",
                         i, obs[2:0], obs[21:11], obs[10:9], obs[8:3],
                         vexp[i][2:0], vexp[i][21:11], vexp[i][10:9], vexp[i][8:3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_primask();
        vin.delete(); vexp.delete();
        for (int k = 0; k < 3; k++) begin
            vin.push_back(iv(0, C_NOP, 0, 1, 1, 1, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
            vin.push_back(iv(0, C_NOP, 0, 0, 1, 1, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
            vin.push_back(iv(0, C_NOP, 0, 0, 1, 1, 0)); vexp.push_back(ev(S_EXE, B_PC, 0, 0));
        end
        vin.push_back(iv(0, C_NOP, 0, 1, 1, 1, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 1, 1, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 1, 0, 0)); vexp.push_back(ev(S_EXE, B_PC, 0, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_SP | B_LR, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_IPSR | B_PC | B_ACK, 2, 6'd16));
        for (int i = 0; i < vin.size(); i++) begin
            {rst, inst_class, set_flags, mem_ready, irq_req, primask, halt} = vin[i];
            #1;
            n_checks++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL primask row %0d: got st=%0d strb=%b pc=%0d exc=%0d, want st=%0d strb=%b pc=%0d exc=%0d",
                         i, obs[2:0], obs[21:11], obs[10:9], obs[8:3],
                         vexp[i][2:0], vexp[i][21:11], vexp[i][10:9], vexp[i][8:3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_faults();
        vin.delete(); vexp.delete();
        // Stuck fetch: counts 0..15 without ready, fault on the 16th cycle.
        for (int k = 0; k < 16; k++) begin
            vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        end
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_SP | B_LR, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_IPSR | B_PC, 2, 6'd3));
        // Ready arriving exactly when the count hits the limit wins.
        for (int k = 0; k < 15; k++) begin
            vin.push_back(iv(0, C_UND, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        end
        vin.push_back(iv(0, C_UND, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_UND, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        // UNDEF with a simultaneous unmasked IRQ: fault cause wins.
        vin.push_back(iv(0, C_UND, 0, 0, 1, 0, 0)); vexp.push_back(ev(S_EXE, 0, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_SP | B_LR, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_IPSR | B_PC, 2, 6'd3));
        for (int i = 0; i < vin.size(); i++) begin
            {rst, inst_class, set_flags, mem_ready, irq_req, primask, halt} = vin[i];
            #1;
            n_checks++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL faults row %0d: got st=%0d strb=%b pc=%0d exc=%0d, want st=%0d strb=%b pc=%0d exc=%0d",
                         i, obs[2:0], obs[21:11], obs[10:9], obs[8:3],
                         vexp[i][2:0], vexp[i][21:11], vexp[i][10:9], vexp[i][8:3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt_rst();
        vin.delete(); vexp.delete();
        // LOAD, then halt at the WB boundary, release with halt=0.
        vin.push_back(iv(0, C_LD, 0, 1, 0, 0, 1)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 1)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 1)); vexp.push_back(ev(S_EXE, 0, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 1, 0, 0, 1)); vexp.push_back(ev(S_MEM, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 1)); vexp.push_back(ev(S_WB, B_RD | B_PC, 0, 0));
        vin.push_back(iv(0, C_LD, 0, 1, 0, 0, 1)); vexp.push_back(ev(S_HLT, 0, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 1, 0, 0, 1)); vexp.push_back(ev(S_HLT, 0, 3, 0));
        vin.push_back(iv(0, C_LD, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_HLT, 0, 3, 0));
        // NOP, halt again, then an IRQ wakes HALT.
        vin.push_back(iv(0, C_NOP, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 1)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 1)); vexp.push_back(ev(S_EXE, B_PC, 0, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 1, 0, 1)); vexp.push_back(ev(S_HLT, 0, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_SP | B_LR, 3, 0));
        vin.push_back(iv(0, C_NOP, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXC, B_IPSR | B_PC | B_ACK, 2, 6'd16));
        // STORE interrupted by reset while the write is outstanding.
        vin.push_back(iv(0, C_ST, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_DEC, B_DEC, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_EXE, 0, 3, 0));
        vin.push_back(iv(1, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_MEM, B_MREQ | B_WR, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 0, 0, 0, 0)); vexp.push_back(ev(S_RST, 0, 3, 0));
        vin.push_back(iv(0, C_ST, 0, 1, 0, 0, 0)); vexp.push_back(ev(S_FET, B_MREQ, 3, 0));
        for (int i = 0; i < vin.size(); i++) begin
            {rst, inst_class, set_flags, mem_ready, irq_req, primask, halt} = vin[i];
            #1;
            n_checks++;
            if (obs !== vexp[i]) begin
                n_fail++;
                $display("FAIL halt_rst row %0d: got st=%0d strb=%b pc=%0d exc=%0d, want st=%0d strb=%b pc=%0d exc=%0d",
                         i, obs[2:0], obs[21:11], obs[10:9], obs[8:3],
                         vexp[i][2:0], vexp[i][21:11], vexp[i][10:9], vexp[i][8:3]);
            end
            @(negedge clk);
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        rst        = 1'b1;
        inst_class = 3'd0;
        set_flags  = 1'b0;
        mem_ready  = 1'b0;
        irq_req    = 1'b0;
        primask    = 1'b0;
        halt       = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_dp();
        test_load_store();
        test_irq_bl();
        test_primask();
        test_faults();
        test_halt_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
